// File: rtl/decode_regread.sv
// Y86-64 decode stage: register file, source/destination decode, E/M/W operand forwarding and E pipeline register.
// Optional WSTAT_GUARD_EN: register-file writes only happen when W_stat is AOK.
module decode_regread #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned NREGS        = 15,
  parameter bit          REG_INIT_IDX = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        D_stat,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_stat,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  input  logic              E_stall,
  input  logic              E_bubble,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RRSP     = 4'h4;
  localparam logic [3:0] STAT_AOK = 4'h1;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef struct packed {
    logic [3:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [DATA_W-1:0] val_c;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [3:0]        src_a;
    logic [3:0]        src_b;
  } e_reg_t;

  localparam e_reg_t E_NOP = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    val_c: '0,
    val_a: '0,
    val_b: '0,
    dst_e: RNONE,
    dst_m: RNONE,
    src_a: RNONE,
    src_b: RNONE
  };

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_en;
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  e_reg_t            e_d;
  e_reg_t            e_q;

`ifdef WSTAT_GUARD_EN
  assign wr_en = (W_stat == STAT_AOK);
`else
  logic unused_w_stat;
  assign unused_w_stat = ^W_stat;
  assign wr_en         = 1'b1;
`endif

  // Register file; when both W ports target one register the valM write lands last and wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= REG_INIT_IDX ? DATA_W'(i) : '0;
      end
    end else if (wr_en) begin
      if (W_dstE != RNONE) regs[W_dstE] <= W_valE;
      if (W_dstM != RNONE) regs[W_dstM] <= W_valM;
    end
  end

  // Source / destination decode from the instruction code.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    dst_e  = RNONE;
    dst_m  = RNONE;
    case (D_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
      I_RET, I_POPQ:                      d_srcA = RRSP;
      default:                            d_srcA = RNONE;
    endcase
    case (D_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_srcB = RRSP;
      default:                            d_srcB = RNONE;
    endcase
    case (D_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = RRSP;
      default:                            dst_e = RNONE;
    endcase
    case (D_icode)
      I_MRMOVQ, I_POPQ:                   dst_m = D_rA;
      default:                            dst_m = RNONE;
    endcase
  end

  // Raw register-file reads; ID F has no storage and reads as zero.
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    if (d_srcA != RNONE) rf_a = regs[d_srcA];
    if (d_srcB != RNONE) rf_b = regs[d_srcB];
  end

  // Youngest producer first: e, then M (load before ALU), then W (load before ALU), then the file.
  function automatic logic [DATA_W-1:0] forward(input logic [3:0] src,
                                                input logic [DATA_W-1:0] rf_val);
    logic [DATA_W-1:0] v;
    v = rf_val;
    if (src == RNONE)       v = '0;
    else if (src == e_dstE) v = e_valE;
    else if (src == M_dstM) v = m_valM;
    else if (src == M_dstE) v = M_valE;
    else if (src == W_dstM) v = W_valM;
    else if (src == W_dstE) v = W_valE;
    return v;
  endfunction

  always_comb begin
    fwd_a = forward(d_srcA, rf_a);
    fwd_b = forward(d_srcB, rf_b);
  end

  // Next E payload; jXX and call carry the fall-through PC in valA.
  always_comb begin
    e_d       = E_NOP;
    e_d.stat  = D_stat;
    e_d.icode = D_icode;
    e_d.ifun  = D_ifun;
    e_d.val_c = D_valC;
    e_d.val_a = (D_icode == I_JXX || D_icode == I_CALL) ? D_valP : fwd_a;
    e_d.val_b = fwd_b;
    e_d.dst_e = dst_e;
    e_d.dst_m = dst_m;
    e_d.src_a = d_srcA;
    e_d.src_b = d_srcB;
  end

  // E pipeline register: stall holds, bubble injects a NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= E_NOP;
    end else if (!E_stall) begin
      e_q <= E_bubble ? E_NOP : e_d;
    end
  end

  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.val_c;
  assign E_valA  = e_q.val_a;
  assign E_valB  = e_q.val_b;
  assign E_dstE  = e_q.dst_e;
  assign E_dstM  = e_q.dst_m;
  assign E_srcA  = e_q.src_a;
  assign E_srcB  = e_q.src_b;

endmodule
